// File: rtl/branch_tournament_update.sv
// Tournament predictor chooser trainer: buffers resolved branches, applies the
// 2-bit saturating chooser update and forwards each outcome to the component predictors.
module branch_tournament_update #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [1:0]  INIT_VALUE = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        update_valid,
    output logic        update_ready,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic        hist_correct,
    input  logic        glob_correct,
    output logic        train_valid,
    input  logic        train_ready,
    output logic [31:0] train_pc,
    output logic        train_taken,
    input  logic [31:0] rd_pc,
    output logic        rd_choose_global,
    output logic        init_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        hist_ok;
        logic        glob_ok;
    } outcome_t;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    // Only the low three bits of the nibble fold reach the index.
    function automatic logic [6:0] pc_index(input logic [31:0] pc);
        logic [2:0] fold;
        fold = '0;
        for (int i = 0; i < 8; i++) fold ^= pc[4*i +: 3];
        return {fold, pc[3:0]};
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic hist_ok,
                                            input logic glob_ok);
        if (glob_ok && !hist_ok) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        if (hist_ok && !glob_ok) return (ctr == 2'b00) ? ctr : ctr - 2'b01;
        return ctr;
    endfunction

    state_t      state_q;
    logic [6:0]  sweep_q;
    logic        init_done_q;

    logic [1:0]  cpht_q [128];
    outcome_t    fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;

    logic        s1_valid_q, s1_valid_d;
    outcome_t    s1_out_q, s1_out_d;
    logic [6:0]  s1_idx_q, s1_idx_d;
    logic [1:0]  s1_ctr_q, s1_ctr_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_pc_q, s2_pc_d;
    logic        s2_taken_q, s2_taken_d;
    logic [6:0]  s2_idx_q, s2_idx_d;
    logic [1:0]  s2_ctr_q, s2_ctr_d;

    logic        wr_en;
    logic [6:0]  wr_idx;
    logic [1:0]  wr_data;
    logic        fifo_full, push, pop, train_hs, s2_free, s1_adv;
    logic [1:0]  s1_cur;
    outcome_t    head;
    logic [6:0]  head_idx;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + 7'd1;
                    if (sweep_q == 7'd127) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_full        = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign update_ready     = init_done_q && !fifo_full;
    assign push             = update_valid && update_ready;
    assign train_hs         = s2_valid_q && train_ready;
    assign s2_free          = !s2_valid_q || train_ready;
    assign s1_adv           = s1_valid_q && s2_free;
    assign pop              = (count_q != '0) && (!s1_valid_q || s1_adv);
    assign head             = fifo_q[rd_ptr_q];
    assign head_idx         = pc_index(head.pc);
    assign rd_choose_global = init_done_q && cpht_q[pc_index(rd_pc)][1];

    assign train_valid = s2_valid_q;
    assign train_pc    = s2_pc_q;
    assign train_taken = s2_taken_q;
    assign init_done   = init_done_q;

    // The init sweep and the retiring stage-2 write share the single chooser write port.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = s2_idx_q;
        wr_data = s2_ctr_q;
        if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = sweep_q;
            wr_data = INIT_VALUE;
        end else if (train_hs) begin
            wr_en = 1'b1;
        end
    end

    // NOTE: arrays are not reset; the init sweep defines the chooser and FIFO slots are only read after a push.
    always_ff @(posedge clk) begin
        if (wr_en) cpht_q[wr_idx] <= wr_data;
        if (push)  fifo_q[wr_ptr_q] <= '{update_pc, update_taken, hist_correct, glob_correct};
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);

        // Stage 1 tracks writes to its index so back-to-back updates see the latest counter.
        s1_cur     = (wr_en && wr_idx == s1_idx_q) ? wr_data : s1_ctr_q;
        s1_valid_d = s1_valid_q;
        s1_out_d   = s1_out_q;
        s1_idx_d   = s1_idx_q;
        s1_ctr_d   = s1_cur;
        if (pop) begin
            s1_valid_d = 1'b1;
            s1_out_d   = head;
            s1_idx_d   = head_idx;
            s1_ctr_d   = (wr_en && wr_idx == head_idx) ? wr_data : cpht_q[head_idx];
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_pc_d    = s2_pc_q;
        s2_taken_d = s2_taken_q;
        s2_idx_d   = s2_idx_q;
        s2_ctr_d   = s2_ctr_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_pc_d    = s1_out_q.pc;
            s2_taken_d = s1_out_q.taken;
            s2_idx_d   = s1_idx_q;
            s2_ctr_d   = ctr_next(s1_cur, s1_out_q.hist_ok, s1_out_q.glob_ok);
        end else if (train_hs) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_out_q   <= '0;
            s1_idx_q   <= '0;
            s1_ctr_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_pc_q    <= '0;
            s2_taken_q <= 1'b0;
            s2_idx_q   <= '0;
            s2_ctr_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            s1_valid_q <= s1_valid_d;
            s1_out_q   <= s1_out_d;
            s1_idx_q   <= s1_idx_d;
            s1_ctr_q   <= s1_ctr_d;
            s2_valid_q <= s2_valid_d;
            s2_pc_q    <= s2_pc_d;
            s2_taken_q <= s2_taken_d;
            s2_idx_q   <= s2_idx_d;
            s2_ctr_q   <= s2_ctr_d;
        end
    end

endmodule

// File: tb/tb_branch_tournament_update.sv
// Scoreboard bench for branch_tournament_update: a reference chooser model predicts
// every train handshake and the chooser bit visible after each write.
module tb_branch_tournament_update;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        update_valid = 1'b0;
    logic        update_ready;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic        hist_correct = 1'b0;
    logic        glob_correct = 1'b0;
    logic        train_valid;
    logic        train_ready = 1'b0;
    logic [31:0] train_pc;
    logic        train_taken;
    logic [31:0] rd_pc;
    logic        rd_choose_global;
    logic        init_done;

    logic [31:0] main_rd_pc = '0;
    logic [31:0] mon_rd_pc = '0;
    logic        rd_sel = 1'b0;
    int          tr_mode = 0;

    assign rd_pc = rd_sel ? mon_rd_pc : main_rd_pc;

    always #5 clk = ~clk;

    branch_tournament_update #(.FIFO_DEPTH(4), .INIT_VALUE(2'b01)) dut (
        .clk(clk), .reset(reset),
        .update_valid(update_valid), .update_ready(update_ready),
        .update_pc(update_pc), .update_taken(update_taken),
        .hist_correct(hist_correct), .glob_correct(glob_correct),
        .train_valid(train_valid), .train_ready(train_ready),
        .train_pc(train_pc), .train_taken(train_taken),
        .rd_pc(rd_pc), .rd_choose_global(rd_choose_global),
        .init_done(init_done)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        int          ctr;
    } exp_t;

    exp_t sb[$];
    int   model_ctr[128];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_fold(input logic [31:0] pc);
        int f = 0;
        for (int i = 0; i < 8; i++) f = f ^ int'((pc >> (4 * i)) & 32'hF);
        return f;
    endfunction

    function automatic int ref_idx(input logic [31:0] pc);
        return (ref_fold(pc) % 8) * 16 + int'(pc % 16);
    endfunction

    function automatic int ref_next(input int c, input bit h, input bit g);
        if (g && !h) return (c >= 3) ? 3 : c + 1;
        if (h && !g) return (c <= 0) ? 0 : c - 1;
        return c;
    endfunction

    // Random PC whose index is i: pick nibble 1 so the fold lands on i's upper bits.
    function automatic logic [31:0] pc_for_idx(input int i, input logic [31:0] rnd);
        logic [31:0] pc;
        int          f;
        pc = (rnd & 32'hFFFF_FF00) | (rnd & 32'h80) | 32'(i % 16);
        f  = ref_fold(pc);
        pc = pc | 32'((((i / 16) ^ f) & 7) << 4);
        return pc;
    endfunction

    // train_ready driver: 0 = held low, 1 = held high, otherwise random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0:       train_ready = 1'b0;
                1:       train_ready = 1'b1;
                default: train_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each train handshake and checks the chooser bit next cycle.
    initial begin
        exp_t e;
        bit   pend = 0;
        bit   pend_bit = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("chooser_after_write", 64'(rd_choose_global), 64'(pend_bit));
                pend = 0;
            end
            if (train_valid && train_ready && !reset) begin
                if (sb.size() == 0) begin
                    check("unexpected_train", 64'(train_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("train_pc", 64'(train_pc), 64'(e.pc));
                    check("train_taken", 64'(train_taken), 64'(e.taken));
                    mon_rd_pc = e.pc;
                    pend      = 1;
                    pend_bit  = (e.ctr >= 2);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Offers one outcome starting just after a rising edge; returns just after a rising edge.
    task automatic send(input logic [31:0] pc, input bit tk, input bit h, input bit g,
                        input int bound, output bit acc);
        int idx;
        update_pc    = pc;
        update_taken = tk;
        hist_correct = h;
        glob_correct = g;
        update_valid = 1'b1;
        acc = 0;
        for (int w = 0; w <= bound; w++) begin
            @(negedge clk);
            if (update_ready) begin
                acc = 1;
                idx = ref_idx(pc);
                model_ctr[idx] = ref_next(model_ctr[idx], h, g);
                sb.push_back('{pc, tk, model_ctr[idx]});
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        update_valid = 1'b0;
    endtask

    task automatic send_ok(input logic [31:0] pc, input bit tk, input bit h, input bit g);
        bit acc;
        send(pc, tk, h, g, 300, acc);
        if (!acc) check("accept_timeout", 64'(update_ready), 64'(1));
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 2000 && sb.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check({"drain_", name}, 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        update_valid = 1'b0;
        rd_sel       = 1'b0;
        main_rd_pc   = 32'h0000_0010;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 128; i++) model_ctr[i] = 1;
        for (int k = 0; k <= 128; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("reset_train_pc", 64'(train_pc), 64'(0));
                check("reset_train_taken", 64'(train_taken), 64'(0));
            end
            check("init_train_valid", 64'(train_valid), 64'(0));
            check("init_done", 64'(init_done), 64'(k == 128));
            check("init_update_ready", 64'(update_ready), 64'(k == 128));
            check("init_chooser_forced", 64'(rd_choose_global), 64'(0));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sweep_model(input string name);
        rd_sel = 1'b0;
        for (int i = 0; i < 128; i++) begin
            main_rd_pc = pc_for_idx(i, $urandom);
            @(negedge clk);
            check(name, 64'(rd_choose_global), 64'(model_ctr[i] >= 2));
            @(posedge clk);
            #1;
        end
        rd_sel = 1'b1;
    endtask

    initial begin
        bit acc;
        int acc_cnt;
        int r;
        logic [31:0] pc;

        tr_mode = 1;
        do_reset();
        sweep_model("init_sweep");

        // Single update: latency to train_valid and chooser visibility.
        send_ok(32'h0000_0010, 1'b1, 1'b0, 1'b1);
        @(negedge clk); check("lat_n1_valid", 64'(train_valid), 64'(0));
        @(negedge clk); check("lat_n2_valid", 64'(train_valid), 64'(0));
        @(negedge clk); check("lat_n3_valid", 64'(train_valid), 64'(1));
        check("lat_n3_pc", 64'(train_pc), 64'(32'h10));
        check("lat_n3_taken", 64'(train_taken), 64'(1));
        @(posedge clk); #1;
        drain("first");

        // Saturate upward, then two back-to-back decrements, then a neutral update.
        for (int i = 0; i < 3; i++) send_ok(32'h0000_0010, 1'b1, 1'b0, 1'b1);
        send_ok(32'h0000_0010, 1'b0, 1'b1, 1'b0);
        send_ok(32'h0000_0010, 1'b0, 1'b1, 1'b0);
        send_ok(32'h0000_0010, 1'b1, 1'b1, 1'b1);
        drain("saturate");

        // Stall capacity: FIFO plus two stages.
        tr_mode = 0;
        acc_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            send(32'h0000_0100 + 32'(k * 4), 1'(k), 1'(k % 3 == 0), 1'(k % 2), 4, acc);
            acc_cnt += int'(acc);
        end
        check("stall_accepted", 64'(acc_cnt), 64'(6));
        @(negedge clk);
        check("stall_update_ready", 64'(update_ready), 64'(0));
        @(posedge clk); #1;
        tr_mode = 1;
        drain("stall");
        @(negedge clk);
        check("stall_ready_back", 64'(update_ready), 64'(1));
        @(posedge clk); #1;

        // Random traffic over aliasing and random PCs with random backpressure.
        tr_mode = 2;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      pc = 32'h0000_0010;
            else if (r < 7) pc = 32'h0000_1010;
            else            pc = pc_for_idx($urandom_range(0, 127), $urandom);
            send_ok(pc, 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        tr_mode = 1;
        drain("random");
        sweep_model("final_sweep");

        // Mid-operation reset with outcomes buffered under stall.
        for (int i = 0; i < 3; i++) send_ok(32'h0000_0010, 1'b1, 1'b0, 1'b1);
        drain("pre_reset");
        rd_sel = 1'b0;
        main_rd_pc = 32'h0000_0010;
        @(negedge clk);
        check("pre_reset_chooser", 64'(rd_choose_global), 64'(model_ctr[16] >= 2));
        @(posedge clk); #1;
        tr_mode = 0;
        for (int i = 0; i < 3; i++) send_ok(32'h0000_2000 + 32'(i), 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("buffered_train_valid", 64'(train_valid), 64'(1));
        @(posedge clk); #1;
        do_reset();
        tr_mode = 1;
        sweep_model("post_reset_sweep");
        send_ok(32'h0000_1010, 1'b0, 1'b0, 1'b1);
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_tournament_update.md
# branch_tournament_update

Training side of the tournament branch predictor. Accepts resolved-branch outcomes from the execute stage, owns the 128-entry 2-bit chooser table (CPHT), applies the saturating-counter update, and forwards each outcome to the history/global component predictors for their own training. Exposes a combinational chooser read port used by the fetch-stage prediction logic. Sits between execute writeback and the predictor at fetch.

## Interface

- FIFO_DEPTH, 4, outcome buffer entries (power of two, ≥2)
- INIT_VALUE, 2'b01, chooser value written to every entry at init (weakly history)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- update_valid  in  1  resolved-branch outcome offered
- update_ready  out  1  outcome accepted when update_valid && update_ready
- update_pc  in  32  branch PC
- update_taken  in  1  actual direction
- hist_correct  in  1  history predictor was correct for this branch
- glob_correct  in  1  global predictor was correct for this branch
- train_valid  out  1  training request to component predictors
- train_ready  in  1  components accept request
- train_pc  out  32  PC of training request
- train_taken  out  1  direction of training request
- rd_pc  in  32  fetch PC for chooser lookup
- rd_choose_global  out  1  1 = use global predictor, 0 = use history predictor
- init_done  out  1  table initialisation complete

## Operation

- Index: fold = XOR of the eight nibbles of pc; idx[6:0] = {fold[2:0], pc[3:0]}; same function for update_pc and rd_pc.
- Counter encoding: 00 strongly history, 01 weakly history, 10 weakly global, 11 strongly global; rd_choose_global = CPHT[idx(rd_pc)][1], forced 0 while !init_done.
- Update rule: glob_correct && !hist_correct → increment, saturate at 11; hist_correct && !glob_correct → decrement, saturate at 00; equal → value unchanged (write of same value permitted).
- State machine: INIT → RUN. INIT: 7-bit sweep counter writes INIT_VALUE to entries 0..127, one per cycle; update_ready=0. After entry 127 written → RUN, init_done=1. RUN is left only by reset.
- Path: input FIFO → stage 1 (register outcome, read CPHT[idx]) → stage 2 (compute new counter, drive train_*). CPHT write and stage-2 retire occur in the cycle train_valid && train_ready.
- Stall: stage 2 holds while train_valid && !train_ready; stage 1 holds while stage 2 holds; FIFO pops only when stage 1 empty or advancing.
- Forwarding: in any cycle CPHT[i] is written, a stage-1 entry with index i (held or being loaded) captures the written value, not the array value.
- update_ready = init_done && FIFO not full; push while full impossible; push and pop in same cycle allowed when not full.
- Every accepted outcome produces exactly one train handshake, in order.

## Timing

- Reset values: update_ready 0, init_done 0, train_valid 0, train_pc 0, train_taken 0, FIFO empty, stages empty, sweep counter 0.
- Reset deasserted cycle 0: entries written cycles 0..127; init_done=1 and update_ready=1 from cycle 128.
- Unstalled latency: handshake in cycle N → popped N+1 → stage 1 valid N+2 → train_valid=1 in N+3; write commits at end of N+3; rd_choose_global reflects it from N+4.
- Sustained throughput 1 outcome/cycle with train_ready=1.
- Capacity under stall: FIFO_DEPTH + 2 outcomes.
- Reset mid-operation: FIFO and stages discarded (no train handshake for them), train_valid 0 next cycle, INIT restarts from entry 0.
- rd port is combinational on array; same-cycle write not visible until next cycle.

## Test plan

- Reset, release → init_done rises at cycle 128; rd_pc sweep over all 128 indices gives rd_choose_global=0; update_ready=0 throughout cycles 0..127.
- pc=0x0000_0010 (idx 0x10), glob_correct=1, hist_correct=0, taken=1, accepted cycle N → train_valid/train_pc=0x10/train_taken=1 in N+3; CPHT[0x10]=10, rd_choose_global=1 from N+4.
- Three more identical updates → CPHT[0x10] saturates at 11; then hist_correct=1,glob_correct=0 twice back-to-back → 10 then 01 via forwarding, rd_choose_global=0; hist=glob=1 → unchanged.
- train_ready=0, offer 8 outcomes → exactly 6 accepted, update_ready low; raise train_ready → 6 train handshakes in original order, update_ready returns.
- Back-to-back updates to idx 0x10 and an aliasing PC 0x0000_1010 (fold 0 → idx 0x00, distinct) interleaved with stall toggling → per-index final values match reference counter model.
- With 3 outcomes buffered and train_ready=0, assert reset 1 cycle → train_valid 0, no handshakes for buffered outcomes, init_done 0 then 1 after 128 cycles, all entries 01.
